data_ram_arbiter: RTL

Two-requester arbiter and sequencer in front of the 1024×32 single-port data RAM. It accepts load/store requests from master 0 (CPU load/store unit) and master 1 (debug/initialisation loader), and grants them round-robin. It drives the RAM's WE/RE/A/WD pins for exactly one access cycle per request and returns registered read data with a done pulse. It sits between the memory stage and the data RAM, and the RAM's combinational read port is its only data source.

---
 rtl/data_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// ============================================================================
// data_ram_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Two-requester arbiter and sequencer in front of the single-port data RAM.
//   Master 0 (CPU load/store unit) and master 1 (debug/initialisation loader)
//   are granted round-robin. Each granted request gets exactly one RAM access
//   cycle, followed by a one-cycle done pulse to its owner. Read data is
//   captured from the RAM's combinational read port into a per-master
//   register and held until that master's next completion.
//
//   Sequence per request: IDLE (arbitrate + latch) -> ACCESS (drive RAM pins)
//   -> DONE (pulse owner's done) -> IDLE. Sustained rate is one access per
//   three cycles.
//
// Optional feature:
//   DATA_RAM_ARB_BOUNDS_CHK_EN - when defined, a request whose address has
//   any bit set above ADDR_W is not issued to the RAM; its owner's rdata is
//   loaded with 0 and err pulses together with done. When undefined the
//   address is simply truncated and err is tied low.
//
// Parameters:
//   ADDR_W    word-address width; RAM depth is 2**ADDR_W words
//
// Ports:
//   clk       system clock, all state changes on posedge
//   rst_n     synchronous active-low reset
//   m0_req    master 0 request, held with stable fields until m0_done
//   m0_we     master 0 direction, 1 = write, 0 = read
//   m0_addr   master 0 word address
//   m0_wdata  master 0 write data
//   m0_done   master 0 one-cycle completion pulse
//   m0_rdata  master 0 read data, valid with m0_done, held afterwards
//   m1_*      same set of signals for master 1
//   err       address-error pulse coincident with done
//   ram_we    RAM write enable
//   ram_re    RAM read enable
//   ram_a     RAM word address, zero-extended from ADDR_W bits
//   ram_wd    RAM write data
//   ram_rd    RAM combinational read data
// ============================================================================
module data_ram_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic [31:0] m1_rdata,

    output logic        err,

    output logic        ram_we,
    output logic        ram_re,
    output logic [31:0] ram_a,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    // Latched request, owner and round-robin pointer
    logic              r_lastOwner;
    logic              r_owner;
    logic              r_we;
    logic              r_flag;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    // Per-master read data holding registers
    logic [31:0]       r_m0Rdata;
    logic [31:0]       r_m1Rdata;

    logic              w_anyReq;
    logic              w_winner;
    logic              w_grant;
    logic              w_selWe;
    logic              w_selFlag;
    logic [31:0]       w_selAddr;
    logic [31:0]       w_selWdata;
    logic              w_capture;
    logic [31:0]       w_capData;

    // ------------------------------------------------------------------------
    // Arbitration. Master 1 wins when it is the only requester, or when both
    // request and master 0 was the previous owner. last_owner comes out of
    // reset as 1, so master 0 takes the first tie.
    // ------------------------------------------------------------------------
    assign w_anyReq   = m0_req | m1_req;
    assign w_winner   = m1_req & (~m0_req | ~r_lastOwner);
    assign w_grant    = (r_state == IDLE) & w_anyReq;

    assign w_selWe    = w_winner ? m1_we    : m0_we;
    assign w_selAddr  = w_winner ? m1_addr  : m0_addr;
    assign w_selWdata = w_winner ? m1_wdata : m0_wdata;

    // ------------------------------------------------------------------------
    // Out-of-range detection on the winning address. Without the bounds
    // check the upper address bits are intentionally discarded.
    // ------------------------------------------------------------------------
`ifdef DATA_RAM_ARB_BOUNDS_CHK_EN
    assign w_selFlag = |w_selAddr[31:ADDR_W];
`else
    logic w_unusedAddrHigh;
    assign w_unusedAddrHigh = |w_selAddr[31:ADDR_W];
    assign w_selFlag        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register. Reset from any state drops the pending access.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Only IDLE looks at the requests; ACCESS and DONE
    // always last exactly one cycle each.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                w_nextState = DONE;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic. RAM pins are idle (all zero) outside ACCESS. The enables
    // are qualified with rst_n so a reset arriving during ACCESS can never
    // let a write commit, and are suppressed for a flagged address.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        ram_a   = '0;
        ram_wd  = '0;
        m0_done = 1'b0;
        m1_done = 1'b0;
        case (r_state)
            ACCESS: begin
                ram_a  = {{(32-ADDR_W){1'b0}}, r_addr};
                ram_wd = r_wdata;
                ram_we = r_we  & ~r_flag & rst_n;
                ram_re = ~r_we & ~r_flag & rst_n;
            end
            DONE: begin
                m0_done = ~r_owner;
                m1_done = r_owner;
            end
            default: begin
            end
        endcase
    end

`ifdef DATA_RAM_ARB_BOUNDS_CHK_EN
    assign err = (r_state == DONE) & r_flag;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Request latch. The winner's fields and owner id are captured on the
    // grant edge and held through ACCESS and DONE, so the masters' fields
    // only need to be stable up to the grant. The round-robin pointer
    // follows every grant.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastOwner <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_flag      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else if (w_grant) begin
            r_lastOwner <= w_winner;
            r_owner     <= w_winner;
            r_we        <= w_selWe;
            r_flag      <= w_selFlag;
            r_addr      <= w_selAddr[ADDR_W-1:0];
            r_wdata     <= w_selWdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read data capture. At the end of ACCESS a read loads the RAM's
    // combinational output into the owner's register; a flagged request
    // (read or write) loads 0 instead. Successful writes leave the owner's
    // previous read data untouched.
    // ------------------------------------------------------------------------
    assign w_capture = (r_state == ACCESS) & (~r_we | r_flag);
    assign w_capData = r_flag ? 32'd0 : ram_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m0Rdata <= '0;
            r_m1Rdata <= '0;
        end else if (w_capture) begin
            if (r_owner) begin
                r_m1Rdata <= w_capData;
            end else begin
                r_m0Rdata <= w_capData;
            end
        end
    end

    assign m0_rdata = r_m0Rdata;
    assign m1_rdata = r_m1Rdata;

endmodule
